// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants and types for the keypad scan controller
//
// Purpose: key code constants, column one-hot drive patterns, FSM state
// encoding, the per-frame candidate type with its NONE flag, and two small
// helpers for reading the 4-bit row vector.
// Ports: none (package).

package keypad_pkg;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;
  localparam logic [3:0] KEY_STAR = KEY_E;
  localparam logic [3:0] KEY_HASH = KEY_F;

  // Column drive patterns; bit3 is column0.
  localparam logic [3:0] COL0_ON = 4'b1000;
  localparam logic [3:0] COL1_ON = 4'b0100;
  localparam logic [3:0] COL2_ON = 4'b0010;
  localparam logic [3:0] COL3_ON = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HELD     = 2'd2,
    ST_REL_DB   = 2'd3
  } kp_state_e;

  // Result of one scan frame: either a single key code or NONE.
  typedef struct packed {
    logic       none;
    logic [3:0] code;
  } cand_t;

  localparam cand_t CAND_NONE = '{none: 1'b1, code: 4'h0};

  function automatic logic [2:0] pop4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // Row number of a one-hot row vector (bit3 is row0).
  function automatic logic [1:0] row_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b1000: idx = 2'd0;
      4'b0100: idx = 2'd1;
      4'b0010: idx = 2'd2;
      4'b0001: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_code_map.sv
// rtl/keypad_code_map.sv - (row, column) position to key code lookup
//
// Purpose: combinational translation of a keypad matrix position into the
// 4-bit key code printed on that key.
// Ports:
//   row_idx  in  2  row number 0..3
//   col_idx  in  2  column number 0..3
//   code     out 4  key code

module keypad_code_map
  import keypad_pkg::*;
(
  input  logic [1:0] row_idx,
  input  logic [1:0] col_idx,
  output logic [3:0] code
);

  always_comb begin
    code = KEY_0;
    case ({row_idx, col_idx})
      4'h0: code = KEY_1;
      4'h1: code = KEY_2;
      4'h2: code = KEY_3;
      4'h3: code = KEY_A;
      4'h4: code = KEY_4;
      4'h5: code = KEY_5;
      4'h6: code = KEY_6;
      4'h7: code = KEY_B;
      4'h8: code = KEY_7;
      4'h9: code = KEY_8;
      4'hA: code = KEY_9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = KEY_0;
      4'hE: code = KEY_HASH;
      4'hF: code = KEY_D;
      default: code = KEY_0;
    endcase
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 matrix keypad scanner with frame debounce
//
// Purpose: strobes the columns one at a time, samples synchronised rows at
// the end of each column dwell, resolves one key per frame and debounces
// press/release over whole frames.
// Ports:
//   clk, rst    in  1  clock, synchronous active-high reset
//   rows        in  4  asynchronous row lines, bit3 = row0
//   columns     out 4  one-hot column drive, bit3 = column0
//   key         out 4  last accepted key code
//   key_valid   out 1  accepted key currently held
//   key_strobe  out 1  one-cycle pulse per accepted press
//   multi_key   out 1  one-cycle pulse after a frame with several keys

module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_strobe,
  output logic       multi_key
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  STAB_TGT = 4'(DEBOUNCE_CNT);
  localparam bit          DB_ONE   = (DEBOUNCE_CNT <= 1);

  logic [3:0]  sync1_q, sync2_q;
  logic [15:0] div_q, div_d;
  logic [1:0]  col_q, col_d;
  // Keys seen so far this frame: 0, 1, or 2 meaning "more than one".
  logic [1:0]  acc_cnt_q, acc_cnt_d;
  logic [1:0]  acc_row_q, acc_row_d, acc_col_q, acc_col_d;
  kp_state_e   state_q, state_d;
  logic [3:0]  stab_q, stab_d, stab_inc;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  key_q, key_d;
  logic        valid_q, valid_d, strobe_q, strobe_d, multi_q, multi_d;

  logic        sample, frame_end, frame_single, frame_multi;
  logic [2:0]  pop;
  logic [1:0]  map_row, map_col;
  logic [3:0]  map_code;
  cand_t       cand;
  logic        match_pend, match_key;

  assign sample    = (div_q == DIV_LAST);
  assign frame_end = sample && (col_q == 2'd3);
  assign pop       = pop4(sync2_q);

  // The last column's rows are folded in directly rather than via the
  // accumulator, so the frame decision is made on the column3 sample cycle.
  assign frame_single = ((acc_cnt_q == 2'd0) && (pop == 3'd1)) ||
                        ((acc_cnt_q == 2'd1) && (pop == 3'd0));
  assign frame_multi  = ((acc_cnt_q != 2'd0) || (pop != 3'd0)) && !frame_single;
  assign map_row      = (acc_cnt_q == 2'd0) ? row_index(sync2_q) : acc_row_q;
  assign map_col      = (acc_cnt_q == 2'd0) ? col_q : acc_col_q;

  keypad_code_map u_code_map (
    .row_idx (map_row),
    .col_idx (map_col),
    .code    (map_code)
  );

  always_comb begin
    cand = CAND_NONE;
    if (frame_single) begin
      cand.none = 1'b0;
      cand.code = map_code;
    end
  end

  always_comb begin
    div_d     = sample ? 16'd0 : div_q + 16'd1;
    col_d     = sample ? col_q + 2'd1 : col_q;
    acc_cnt_d = acc_cnt_q;
    acc_row_d = acc_row_q;
    acc_col_d = acc_col_q;
    if (frame_end) begin
      acc_cnt_d = 2'd0;
      acc_row_d = 2'd0;
      acc_col_d = 2'd0;
    end else if (sample && (pop != 3'd0)) begin
      acc_cnt_d = ((acc_cnt_q == 2'd0) && (pop == 3'd1)) ? 2'd1 : 2'd2;
      if (acc_cnt_q == 2'd0) begin
        acc_row_d = row_index(sync2_q);
        acc_col_d = col_q;
      end
    end
  end

  always_comb begin
    columns = COL0_ON;
    case (col_q)
      2'd0: columns = COL0_ON;
      2'd1: columns = COL1_ON;
      2'd2: columns = COL2_ON;
      2'd3: columns = COL3_ON;
      default: columns = COL0_ON;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stab_q  <= 4'd0;
      pend_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      pend_q  <= pend_d;
    end
  end

  // FSM next state, evaluated once per frame end
  always_comb begin
    match_pend = !cand.none && (cand.code == pend_q);
    match_key  = !cand.none && (cand.code == key_q);
    stab_inc   = (stab_q == 4'hF) ? stab_q : stab_q + 4'd1;
    state_d    = state_q;
    stab_d     = stab_q;
    pend_d     = pend_q;
    if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (!cand.none) begin
            pend_d  = cand.code;
            stab_d  = 4'd1;
            state_d = DB_ONE ? ST_HELD : ST_PRESS_DB;
          end
        end
        ST_PRESS_DB: begin
          if (match_pend) begin
            stab_d = stab_inc;
            if (stab_inc >= STAB_TGT) state_d = ST_HELD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (!match_key) begin
            stab_d  = 4'd1;
            state_d = DB_ONE ? ST_IDLE : ST_REL_DB;
          end
        end
        ST_REL_DB: begin
          if (!match_key) begin
            stab_d = stab_inc;
            if (stab_inc >= STAB_TGT) state_d = ST_IDLE;
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs, registered so each pulse lands the cycle after frame end
  always_comb begin
    key_d    = key_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    multi_d  = frame_end && frame_multi;
    if ((state_q == ST_IDLE || state_q == ST_PRESS_DB) && state_d == ST_HELD) begin
      key_d    = cand.code;
      valid_d  = 1'b1;
      strobe_d = 1'b1;
    end
    if ((state_q == ST_HELD || state_q == ST_REL_DB) && state_d == ST_IDLE) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 4'd0;
      sync2_q   <= 4'd0;
      div_q     <= 16'd0;
      col_q     <= 2'd0;
      acc_cnt_q <= 2'd0;
      acc_row_q <= 2'd0;
      acc_col_q <= 2'd0;
      key_q     <= 4'd0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      sync1_q   <= rows;
      sync2_q   <= sync1_q;
      div_q     <= div_d;
      col_q     <= col_d;
      acc_cnt_q <= acc_cnt_d;
      acc_row_q <= acc_row_d;
      acc_col_q <= acc_col_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      multi_q   <= multi_d;
    end
  end

  assign key        = key_q;
  assign key_valid  = valid_q;
  assign key_strobe = strobe_q;
  assign multi_key  = multi_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - scoreboard bench for keypad_scan_ctrl

module tb_keypad_scan_ctrl;

  localparam int SD    = 4;
  localparam int DB    = 3;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rows;
  logic [3:0]  columns, key;
  logic        key_valid, key_strobe, multi_key;
  logic [15:0] pressed = 16'd0;   // bit index = row*4 + col

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  bit prev_valid = 1'b0;

  typedef enum int {EV_REL, EV_MULTI, EV_STROBE} ev_e;
  typedef struct {
    ev_e        kind;
    logic [3:0] key;
    int         cyc;
  } ev_t;
  ev_t exp_q[$];

  logic [3:0] code_tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

  // Reference model state
  bit         m_valid = 1'b0;
  logic [3:0] m_key = 4'h0;
  int         m_run = 0;
  logic [3:0] m_run_key = 4'h0;
  int         m_rel = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Keypad model: a pressed switch connects its column line to its row line.
  always_comb begin
    rows = 4'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && columns[3-c]) rows[3-r] = 1'b1;
  end

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rows       (rows),
    .columns    (columns),
    .key        (key),
    .key_valid  (key_valid),
    .key_strobe (key_strobe),
    .multi_key  (multi_key)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input ev_e kind, input logic [3:0] k);
    ev_t e;
    e.kind = kind;
    e.key  = k;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_key = 4'h0; m_run = 0; m_run_key = 4'h0; m_rel = 0;
    exp_q.delete();
  endtask

  // Frame-level behaviour: a key is accepted after DB identical single-key
  // frames starting from idle, and released after DB frames without it.
  task automatic model_frame(input logic [15:0] mask);
    int n, idx;
    bit have;
    logic [3:0] code;
    n = $countones(mask);
    idx = 0;
    for (int i = 0; i < 16; i++) if (mask[i]) idx = i;
    have = (n == 1);
    code = have ? code_tbl[idx] : 4'h0;
    if (m_valid) begin
      if (have && code == m_key) m_rel = 0;
      else begin
        m_rel++;
        if (m_rel >= DB) begin
          m_valid = 1'b0;
          m_rel = 0;
          push_ev(EV_REL, m_key);
        end
      end
      m_run = 0;
    end else begin
      if (m_run > 0) begin
        if (have && code == m_run_key) m_run++;
        else m_run = 0;
      end else if (have) begin
        m_run = 1;
        m_run_key = code;
      end
      if (m_run >= DB) begin
        m_valid = 1'b1;
        m_key = m_run_key;
        m_run = 0;
        push_ev(EV_STROBE, m_key);
      end
    end
    if (n > 1) push_ev(EV_MULTI, 4'h0);
  endtask

  task automatic frame(input logic [15:0] mask);
    pressed = mask;
    repeat (FRAME) @(posedge clk);
    #1;
    model_frame(mask);
  endtask

  task automatic expect_ev(input ev_e kind, input logic [3:0] k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL ev_unexpected: got event %0d key %0h expected none (cycle %0d)", kind, k, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.cyc != cyc || (kind != EV_MULTI && e.key !== k)) begin
      errors++;
      $display("FAIL ev_match: got event %0d key %0h cycle %0d expected event %0d key %0h cycle %0d",
               kind, k, cyc, e.kind, e.key, e.cyc);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL ev_missing: got nothing expected event %0d key %0h at cycle %0d",
                   exp_q[0].kind, exp_q[0].key, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
        check("key_valid_level", 16'(key_valid), 16'(m_valid));
        check("key_level", 16'(key), 16'(m_key));
        if (prev_valid && !key_valid) expect_ev(EV_REL, key);
        if (multi_key) expect_ev(EV_MULTI, key);
        if (key_strobe) expect_ev(EV_STROBE, key);
        prev_valid = key_valid;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_columns"}, 16'(columns), 16'h8);
    check({tag, "_key"}, 16'(key), 16'h0);
    check({tag, "_key_valid"}, 16'(key_valid), 16'h0);
    check({tag, "_key_strobe"}, 16'(key_strobe), 16'h0);
    check({tag, "_multi_key"}, 16'(multi_key), 16'h0);
  endtask

  initial begin
    logic [15:0] mask;
    int k1, k2, kind, len;

    fork monitor(); join_none

    // Reset, then column timing during the first (empty) frame
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    pressed = 16'd0;
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk);
      #1;
      if (i <= 3) check("col_hold", 16'(columns), 16'h8);
      if (i == 4) check("col_step", 16'(columns), 16'h4);
    end
    model_frame(16'd0);

    // Single press of "5" held for 5 frames, then released over 3 frames
    repeat (5) frame(16'h0020);
    check("press5_key", 16'(key), 16'h5);
    check("press5_valid", 16'(key_valid), 16'h1);
    repeat (3) frame(16'h0000);
    check("rel5_valid", 16'(key_valid), 16'h0);
    check("rel5_key", 16'(key), 16'h5);

    // Bouncing "9"
    frame(16'h0400); frame(16'h0000); frame(16'h0400);
    repeat (2) frame(16'h0000);
    check("bounce_valid", 16'(key_valid), 16'h0);

    // "1" and "D" together
    repeat (3) frame(16'h8001);
    check("multi_valid", 16'(key_valid), 16'h0);
    frame(16'h0000);

    // Rollover A -> #
    repeat (4) frame(16'h0008);
    check("roll_a_key", 16'(key), 16'hA);
    repeat (6) frame(16'h4000);
    check("roll_hash_key", 16'(key), 16'hF);
    check("roll_hash_valid", 16'(key_valid), 16'h1);
    repeat (3) frame(16'h0000);

    // Reset in the middle of a press debounce of "7"
    repeat (2) frame(16'h0100);
    repeat (6) @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("abort");
    pressed = 16'd0;
    model_reset();
    prev_valid = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) frame(16'h0100);
    repeat (2) frame(16'h0000);
    check("abort_valid", 16'(key_valid), 16'h0);

    // Random segments of idle, single-key and two-key frames
    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 5);
      k1   = $urandom_range(0, 15);
      k2   = (k1 + 1 + $urandom_range(0, 14)) % 16;
      if (kind < 4) mask = 16'd0;
      else if (kind < 8) mask = 16'd1 << k1;
      else mask = (16'd1 << k1) | (16'd1 << k2);
      repeat (len) frame(mask);
    end
    repeat (DB) frame(16'h0000);

    repeat (2) @(negedge clk);
    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
